// File: rtl/cache_req_if.sv
// Request/response channel between the request sequencer and the cache controller.
interface cache_req_if #(
    parameter int unsigned ADDR_W = 15
) ();
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_hit
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_hit
    );
endinterface

// File: rtl/cache_req_sequencer.sv
// Issues one handshaked cache request per word address from START_ADDR to END_ADDR,
// waits for each hit/miss response, and tallies the run.
module cache_req_sequencer #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned START_ADDR = 1024,
    parameter int unsigned END_ADDR   = 9215,
    parameter int unsigned COUNT_W    = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    cache_req_if.master        bus,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] access_count,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic               proto_err
);
    localparam logic [ADDR_W-1:0]  START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0]  END_A   = ADDR_W'(END_ADDR);
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COUNT_W-1:0] acc_q, acc_d, hit_q, hit_d, miss_q, miss_d;
    logic               perr_q, perr_d;
    logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

    // Next-state, counter and address update; output flags decode the next state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        perr_d  = perr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    addr_d  = START_A;
                    acc_d   = '0;
                    hit_d   = '0;
                    miss_d  = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ISSUE: begin
                if (bus.req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.resp_valid) begin
                    acc_d = sat_inc(acc_q);
                    if (bus.resp_hit) begin
                        hit_d = sat_inc(hit_q);
                    end else begin
                        miss_d = sat_inc(miss_q);
                    end
                    if (addr_q == END_A) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A response is only legitimate while a request is outstanding.
        if (bus.resp_valid && (state_q != ST_WAIT)) begin
            perr_d = 1'b1;
        end else begin
            perr_d = perr_q;
        end
        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= START_A;
            acc_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_valid = valid_q;
    assign bus.req_addr  = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign access_count  = acc_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;
    assign proto_err     = perr_q;
endmodule
